// File: rtl/dbg_bridge_host.sv
// dbg_bridge_host: serialises debug-bridge commands onto a UART byte stream and returns read data.
module dbg_bridge_host #(
  parameter int RSP_TIMEOUT = 1048576,
  parameter int TIMEOUT_W = 21
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [7:0]  cmd_len_i,
  input  logic        wdata_valid_i,
  input  logic [7:0]  wdata_i,
  output logic        wdata_ready_o,
  output logic        rdata_valid_o,
  output logic [7:0]  rdata_o,
  input  logic        rdata_ready_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_accept_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_accept_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  typedef enum logic [3:0] {IDLE, HDR, LEN, ADDR0, ADDR1, ADDR2, ADDR3, WDATA, RDATA, DONE} state_t;
  localparam logic [TIMEOUT_W-1:0] TMO_LIM = TIMEOUT_W'(RSP_TIMEOUT - 1);
  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [31:0]          addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic                 err_q, err_d;
  logic                 tx_xfer, rx_xfer, timeout;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end
  assign tx_xfer = tx_valid_o & tx_accept_i;
  assign rx_xfer = rx_valid_i & rx_accept_o;
  assign tmo_inc = tmo_q + TIMEOUT_W'(1);
  // Only silence on the RX side counts; a held byte blocked by rdata_ready_i keeps the counter frozen.
  assign timeout = (RSP_TIMEOUT != 0) && (state_q == RDATA) && !rx_valid_i && (tmo_inc >= TMO_LIM);
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_d   = (state_q != RDATA || rx_xfer) ? '0 : rx_valid_i ? tmo_q : tmo_inc;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        write_d = cmd_write_i;
        addr_d  = cmd_addr_i;
        len_d   = cmd_len_i;
        cnt_d   = cmd_len_i;
        err_d   = cmd_len_i == 8'd0;
        state_d = (cmd_len_i == 8'd0) ? DONE : HDR;
      end
      HDR, LEN, ADDR0, ADDR1, ADDR2: if (tx_accept_i) state_d = state_t'(state_q + 4'd1);
      ADDR3: if (tx_accept_i) state_d = write_q ? WDATA : RDATA;
      WDATA: if (tx_xfer) begin
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? DONE : WDATA;
      end
      RDATA: if (rx_xfer) begin
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? DONE : RDATA;
      end else if (timeout) begin
        err_d   = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready_o   = state_q == IDLE;
    busy_o        = state_q != IDLE;
    done_o        = state_q == DONE;
    err_o         = (state_q == DONE) & err_q;
    wdata_ready_o = (state_q == WDATA) & tx_accept_i;
    rdata_valid_o = (state_q == RDATA) & rx_valid_i;
    rdata_o       = rx_data_i;
    rx_accept_o   = (state_q != RDATA) | rdata_ready_i;
    tx_valid_o    = (state_q inside {HDR, LEN, ADDR0, ADDR1, ADDR2, ADDR3}) | ((state_q == WDATA) & wdata_valid_i);
    tx_data_o     = (state_q == HDR)   ? {7'b0001000, ~write_q} :
                    (state_q == LEN)   ? len_q :
                    (state_q == ADDR0) ? addr_q[31:24] :
                    (state_q == ADDR1) ? addr_q[23:16] :
                    (state_q == ADDR2) ? addr_q[15:8] :
                    (state_q == ADDR3) ? addr_q[7:0] :
                    (state_q == WDATA) ? wdata_i : 8'h00;
  end
endmodule
